ode_memory_loader: RTL and testbench
====================================

// Module: ode_memory_loader
// PURPOSE
// - Write-side counterpart of the step module's memory reads. Accepts a valid/ready word stream and writes it into the ODE working memory:
//   - N at N_ADDRESS, tolerance at TOLERANCE_ADDRESS, initial step at STEP_ADDRESS;
//   - then N words of x0 from base x0_address and N words of x1 from base x1_address.
// - Signals done so the controller can pulse init/start on the step module.
// PARAMETERS
// - WORD_SIZE          16  data word width
// - ADDRESS_WIDTH      4   memory address width
// - N_ADDRESS          5   address of N
// - TOLERANCE_ADDRESS  6   address of tolerance
// - STEP_ADDRESS       7   address of initial step
// PORTS
// - clk             in   1   single clock; all state updates on posedge
// - rst             in   1   asynchronous, active-low reset
// - start           in   1   begin load; x0_address/x1_address sampled this cycle
// - x0_address      in   AW  x0 vector base
// - x1_address      in   AW  x1 vector base
// - in_valid        in   1   in_data valid
// - in_data         in   WS  stream word
// - in_ready        out  1   loader accepts in_data this cycle
// - mem_we          out  1   memory write enable (registered)
// - mem_address     out  AW  write address (registered)
// - mem_data        out  WS  write data (registered)
// - busy            out  1   high in any load state
// - done            out  1   load complete; held until next start
// - error_format    out  1   N illegal; held until next start
// - error_checksum  out  1   checksum mismatch; held until next start (0 without macro)
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; all outputs 0; counters/bases cleared. Reset mid-load abandons the transfer; no further writes.
// - States: IDLE -> HDR_N -> HDR_TOL -> HDR_STEP -> X0 -> X1 [-> CSUM] -> DONE | ERR.
// - IDLE/DONE/ERR:
//   - start=1 latches bases, clears done/error flags and the running sum, and moves to HDR_N.
//   - start is ignored in every other state.
// - in_ready = 1 in HDR_N..CSUM, else 0. A word transfers when in_valid & in_ready, at most one per cycle; stalls hold state.
// - Write latency: a word accepted in cycle t appears as mem_we=1 with its address/data in cycle t+1.
//   - mem_we=0 in any cycle without a write. mem_address/mem_data hold their last values.
// - HDR_N: accepted N is legal iff N != 0, N <= 2^AW - x0_base, and N <= 2^AW - x1_base. Compare at WS+1 bits; no wrap.
//   - Legal: write N to N_ADDRESS; load the element counter with N.
//   - Illegal: no write; go to ERR with error_format=1.
// - HDR_TOL/HDR_STEP: write to TOLERANCE_ADDRESS/STEP_ADDRESS.
// - X0: k-th accepted word (k=0..N-1) is written to x0_base+k. After N words, reload the counter with N and go to X1.
// - X1: same as X0, using x1_base.
// - Vector overlap with headers or with each other is not checked; the later write wins.
// - DONE: done=1, busy=0. The final mem_we pulse occurs in the first DONE cycle.
// - Running sum: WS-bit modulo-2^WS sum of every accepted word except the checksum word (N, tol, step, x0s, x1s).
// CONFIGURATION
// - Macro LOADER_CHECKSUM_EN.
// - Defined:
//   - After the last x1 word, enter CSUM and accept one more word; it is never written to memory.
//   - Match with the running sum: go to DONE.
//   - Mismatch: go to ERR with error_checksum=1 and done=0. Data already written stays in memory.
// - Undefined: no CSUM state; X1 goes straight to DONE; error_checksum tied 0.
// TESTING
// - Reset then start, bases x0=8/x1=12, stream 4,0x0100,0x0040,1,2,3,4,5,6,7,8 with in_valid held
//   -> 11 writes in order: (5,4) (6,0x100) (7,0x40) (8..11,1..4) (12..15,5..8); done=1 after the last write.
// - Same stream with in_valid toggled every other cycle
//   -> identical write sequence; no write occurs in a cycle following a non-transfer.
// - x0=14, N=3 -> no write, error_format=1, in_ready=0. Next start with x0=13, N=3 -> load succeeds.
// - N=0 -> error_format=1, no writes. N=16 with both bases 0 -> legal, 35 writes.
// - rst low mid-X0 (after 2 vector words) -> all outputs 0 immediately; no writes until a new start.
// - LOADER_CHECKSUM_EN, stream N=1,1,1,x0=1,x1=1:
//   - checksum 5 -> done=1;
//   - checksum 6 -> error_checksum=1, done=0, 5 writes made.

Source files
------------

// File: rtl/ode_memory_loader.sv
// ode_memory_loader: streams N, tolerance, step, x0[N], x1[N] into the ODE working memory.
// Accepted word is written one cycle later; in_ready only in load states, stalls hold state.
// Optional trailing checksum word is enabled by `define LOADER_CHECKSUM_EN.
module ode_memory_loader #(
  parameter int WORD_SIZE         = 16,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int N_ADDRESS         = 5,
  parameter int TOLERANCE_ADDRESS = 6,
  parameter int STEP_ADDRESS      = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] x0_address,
  input  logic [ADDRESS_WIDTH-1:0] x1_address,
  input  logic                     in_valid,
  input  logic [WORD_SIZE-1:0]     in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error_format,
  output logic                     error_checksum
);

  localparam int WS = WORD_SIZE;
  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = AW + 1;
  localparam logic [WS:0]   SPACE    = (WS+1)'(2**AW);
  localparam logic [AW-1:0] N_ADDR   = AW'(N_ADDRESS);
  localparam logic [AW-1:0] TOL_ADDR = AW'(TOLERANCE_ADDRESS);
  localparam logic [AW-1:0] STP_ADDR = AW'(STEP_ADDRESS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_N,
    S_HDR_TOL,
    S_HDR_STEP,
    S_X0,
    S_X1,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [AW-1:0]   x0_base;
  logic [AW-1:0]   x1_base;
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   n_q;
  logic [WS-1:0]   sum;
  logic            xfer;
  logic            sum_en;
  logic [WS:0]     n_ext;
  logic [WS:0]     x0_room;
  logic [WS:0]     x1_room;
  logic            n_legal;

  assign busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign in_ready = busy;
  assign xfer     = in_valid & in_ready;

  // Room left above each base, computed one bit wider than a word so nothing wraps.
  assign n_ext   = {1'b0, in_data};
  assign x0_room = SPACE - {{(WS+1-AW){1'b0}}, x0_base};
  assign x1_room = SPACE - {{(WS+1-AW){1'b0}}, x1_base};
  assign n_legal = (n_ext != '0) && (n_ext <= x0_room) && (n_ext <= x1_room);

`ifdef LOADER_CHECKSUM_EN
  logic csum_err;
  assign error_checksum = csum_err;
  assign sum_en = xfer && (state != S_CSUM);
`else
  assign error_checksum = 1'b0;
  assign sum_en = xfer;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      x0_base      <= '0;
      x1_base      <= '0;
      ptr          <= '0;
      cnt          <= '0;
      n_q          <= '0;
      sum          <= '0;
      mem_we       <= 1'b0;
      mem_address  <= '0;
      mem_data     <= '0;
      done         <= 1'b0;
      error_format <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_err     <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (sum_en) sum <= sum + in_data;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            x0_base      <= x0_address;
            x1_base      <= x1_address;
            done         <= 1'b0;
            error_format <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_err     <= 1'b0;
`endif
            sum          <= '0;
            state        <= S_HDR_N;
          end
        end
        S_HDR_N: begin
          if (xfer) begin
            if (n_legal) begin
              mem_we      <= 1'b1;
              mem_address <= N_ADDR;
              mem_data    <= in_data;
              cnt         <= in_data[CW-1:0];
              n_q         <= in_data[CW-1:0];
              state       <= S_HDR_TOL;
            end else begin
              error_format <= 1'b1;
              state        <= S_ERR;
            end
          end
        end
        S_HDR_TOL: begin
          if (xfer) begin
            mem_we      <= 1'b1;
            mem_address <= TOL_ADDR;
            mem_data    <= in_data;
            state       <= S_HDR_STEP;
          end
        end
        S_HDR_STEP: begin
          if (xfer) begin
            mem_we      <= 1'b1;
            mem_address <= STP_ADDR;
            mem_data    <= in_data;
            ptr         <= x0_base;
            state       <= S_X0;
          end
        end
        S_X0: begin
          if (xfer) begin
            mem_we      <= 1'b1;
            mem_address <= ptr;
            mem_data    <= in_data;
            ptr         <= ptr + 1'b1;
            cnt         <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              cnt   <= n_q;
              ptr   <= x1_base;
              state <= S_X1;
            end
          end
        end
        S_X1: begin
          if (xfer) begin
            mem_we      <= 1'b1;
            mem_address <= ptr;
            mem_data    <= in_data;
            ptr         <= ptr + 1'b1;
            cnt         <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              done  <= 1'b1;
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // The checksum word is compared against the sum of every earlier word and never stored.
        S_CSUM: begin
          if (xfer) begin
            if (in_data == sum) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              csum_err <= 1'b1;
              state    <= S_ERR;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ode_memory_loader.sv
// Randomized and directed bench for ode_memory_loader against a stream-level reference model.
module tb_ode_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  x0_address;
  logic [3:0]  x1_address;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_address;
  logic [15:0] mem_data;
  logic        busy;
  logic        done;
  logic        error_format;
  logic        error_checksum;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [15:0] stim[$];

  always #5 clk = ~clk;

  ode_memory_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .x0_address(x0_address), .x1_address(x1_address),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .error_format(error_format),
    .error_checksum(error_checksum)
  );

  always @(negedge clk) if (mem_we === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one load of stim[] with the given bases. vmode: 0 valid held, 1 toggled, 2 random.
  task automatic run_load(input logic [3:0] b0, input logic [3:0] b1, input int vmode, input string name);
    int n, nw, acc, idx, cyc;
    bit legal, ok, fmt, csm, pend, v;
    logic [3:0]  wa[$];
    logic [15:0] wd[$];
    logic [3:0]  ea;
    logic [15:0] ed, s;
    n = int'(stim[0]);
    legal = (n != 0) && (n <= 16 - int'(b0)) && (n <= 16 - int'(b1));
    ok = 0; fmt = 0; csm = 0; nw = 0; acc = 1;
    if (legal) begin
      wa.push_back(4'd5); wd.push_back(stim[0]);
      wa.push_back(4'd6); wd.push_back(stim[1]);
      wa.push_back(4'd7); wd.push_back(stim[2]);
      for (int k = 0; k < n; k++) begin wa.push_back(4'(int'(b0) + k)); wd.push_back(stim[3 + k]); end
      for (int k = 0; k < n; k++) begin wa.push_back(4'(int'(b1) + k)); wd.push_back(stim[3 + n + k]); end
      nw = 3 + 2 * n;
      acc = nw;
      ok = 1;
`ifdef LOADER_CHECKSUM_EN
      s = 16'd0;
      for (int k = 0; k < nw; k++) s = s + stim[k];
      acc = nw + 1;
      ok = (stim[nw] == s);
      csm = !ok;
`endif
    end else begin
      fmt = 1;
    end

    @(negedge clk);
    wr_count = 0;
    start = 1'b1; x0_address = b0; x1_address = b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; pend = 0; ea = '0; ed = '0;
    while (1) begin
      check({name, "/we"}, mem_we, pend);
      if (pend) begin
        check({name, "/addr"}, mem_address, ea);
        check({name, "/data"}, mem_data, ed);
      end
      check({name, "/ready"}, in_ready, idx < acc);
      check({name, "/busy"}, busy, idx < acc);
      check({name, "/done"}, done, (idx == acc) && ok);
      check({name, "/efmt"}, error_format, (idx == acc) && fmt);
      check({name, "/ecsum"}, error_checksum, (idx == acc) && csm);
      if (idx == acc) break;
      if (cyc >= 400) begin
        check({name, "/timeout"}, idx, acc);
        break;
      end
      case (vmode)
        0: v = 1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = v ? stim[idx] : 16'($urandom);
      if (vmode == 2) begin
        start = ($urandom_range(0, 5) == 0);
        x0_address = 4'($urandom); x1_address = 4'($urandom);
      end
      @(posedge clk);
      pend = 0;
      if (v) begin
        if (idx < nw) begin pend = 1; ea = wa[idx]; ed = wd[idx]; end
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check({name, "/idle_we"}, mem_we, 1'b0);
      check({name, "/hold_done"}, done, ok);
      check({name, "/hold_efmt"}, error_format, fmt);
      check({name, "/hold_ecsum"}, error_checksum, csm);
    end
    check({name, "/nwrites"}, wr_count, nw);
  endtask

  task automatic set_stim(input int n, input logic [15:0] first[$]);
    stim = first;
    stim.push_front(16'(n));
  endtask

  initial begin
    logic [3:0]  b0, b1;
    logic [15:0] s;
    int n, lim, nv;
    rst = 1'b0; start = 1'b0; x0_address = '0; x1_address = '0;
    in_valid = 1'b0; in_data = '0;
    #1;
    check("rst/we", mem_we, 0);
    check("rst/addr", mem_address, 0);
    check("rst/data", mem_data, 0);
    check("rst/ready", in_ready, 0);
    check("rst/busy", busy, 0);
    check("rst/flags", {done, error_format, error_checksum}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    stim = '{16'd4, 16'h0100, 16'h0040, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'h0168};
    run_load(4'd8, 4'd12, 0, "basic");
    run_load(4'd8, 4'd12, 1, "toggle");

    stim = '{16'd3, 16'd9, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd39};
    run_load(4'd14, 4'd0, 0, "x0_14_n3");
    run_load(4'd13, 4'd0, 0, "x0_13_n3");

    stim = '{16'd0, 16'd1, 16'd2, 16'd3};
    run_load(4'd0, 4'd0, 0, "n0");

    stim = '{16'd16, 16'hAAAA, 16'h5555};
    for (int k = 0; k < 32; k++) stim.push_back(16'(k * 3 + 1));
    s = 16'd0;
    foreach (stim[k]) s = s + stim[k];
    stim.push_back(s);
    run_load(4'd0, 4'd0, 2, "n16");

    // Reset mid-X0: two vector words accepted, then reset asserted between edges.
    stim = '{16'd4, 16'h0100, 16'h0040, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'h0168};
    @(negedge clk);
    start = 1'b1; x0_address = 4'd8; x1_address = 4'd12;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = stim[i];
      @(posedge clk); @(negedge clk);
    end
    in_data = stim[5];
    #2 rst = 1'b0;
    #1;
    check("midrst/we", mem_we, 0);
    check("midrst/addr", mem_address, 0);
    check("midrst/data", mem_data, 0);
    check("midrst/ready", in_ready, 0);
    check("midrst/busy", busy, 0);
    check("midrst/flags", {done, error_format, error_checksum}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst/no_we", mem_we, 0);
      check("midrst/no_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    run_load(4'd8, 4'd12, 2, "after_rst");

`ifdef LOADER_CHECKSUM_EN
    stim = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd5};
    run_load(4'd8, 4'd12, 0, "csum_ok");
    stim = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd6};
    run_load(4'd8, 4'd12, 0, "csum_bad");
`endif

    for (int t = 0; t < 40; t++) begin
      b0 = 4'($urandom); b1 = 4'($urandom);
      lim = (16 - int'(b0) < 16 - int'(b1)) ? 16 - int'(b0) : 16 - int'(b1);
      case ($urandom_range(0, 9))
        0: n = 0;
        1: n = $urandom_range(1, 16);
        2: n = $urandom_range(17, 65535);
        default: n = $urandom_range(1, lim);
      endcase
      stim.delete();
      stim.push_back(16'(n));
      nv = (n <= 16) ? 2 + 2 * n : 4;
      for (int k = 0; k < nv; k++) stim.push_back(16'($urandom));
      s = 16'd0;
      foreach (stim[k]) s = s + stim[k];
      stim.push_back(($urandom_range(0, 1) == 0) ? s : s ^ 16'(1 + $urandom_range(0, 254)));
      run_load(b0, b1, 2, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
